// File: rtl/usb_tx_arbiter_pkg.sv
// Shared types and constants for the USB TX packet arbiter.
// The stall-timeout constant is only used when USB_TX_ARB_TIMEOUT_EN is defined.
package usb_tx_arbiter_pkg;

    typedef enum logic [0:0] {
        ArbIdle,
        ArbBurst
    } usb_tx_arb_state_e;

    localparam int unsigned USB_TX_STALL_TIMEOUT = 1024;
    localparam int unsigned UsbTxDataW           = 32;

endpackage

// File: rtl/usb_tx_arbiter_if.sv
// Requester-side and TX-FIFO-side stream signals of the USB TX arbiter.
// The arbiter takes the slave view; the environment driving requesters takes the master view.
interface usb_tx_arbiter_if #(
    parameter int unsigned NumReq = 2
) ();
    logic [NumReq-1:0][31:0] req_data;
    logic [NumReq-1:0]       req_valid;
    logic [NumReq-1:0]       req_last;
    logic [NumReq-1:0]       req_ready;
    logic [31:0]             tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    modport master (
        output req_data, req_valid, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid
    );

    modport slave (
        input  req_data, req_valid, req_last, tx_ready,
        output req_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/usb_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr+1, ptr+2, ... mod NumReq.
module usb_tx_arbiter_rr_pick #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned off = 1; off <= NumReq; off++) begin
            automatic int unsigned j = 32'(ptr_i) + off;
            if (j >= NumReq) begin
                j = j - NumReq;
            end
            if (!any_o && req_i[j[IdxW-1:0]]) begin
                any_o                = 1'b1;
                idx_o                = j[IdxW-1:0];
                gnt_o[j[IdxW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the single 32-bit TX stream toward the FT601.
// Optional stall timeout enabled by defining USB_TX_ARB_TIMEOUT_EN.
module usb_tx_arbiter
    import usb_tx_arbiter_pkg::*;
#(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned MaxBeats = 512
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    usb_tx_arbiter_if.slave   bus_io,
    output logic [NumReq-1:0] grant_o,
    output logic              busy_o,
    output logic              overflow_o,
    output logic              timeout_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(MaxBeats + 1);

    usb_tx_arb_state_e state_q;
    logic [NumReq-1:0] grant_q;
    logic [IdxW-1:0]   gidx_q;
    logic [IdxW-1:0]   ptr_q;
    logic [CntW-1:0]   cnt_q;
    logic              overflow_q;

    logic [NumReq-1:0] pick_gnt;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_any;
    logic              g_valid;
    logic              g_last;
    logic              xfer;
    logic [CntW-1:0]   cnt_inc;

    usb_tx_arbiter_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .req_i  (bus_io.req_valid),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        g_valid          = bus_io.req_valid[gidx_q];
        g_last           = bus_io.req_last[gidx_q];
        bus_io.tx_data   = bus_io.req_data[gidx_q];
        bus_io.tx_valid  = (state_q == ArbBurst) && g_valid;
        bus_io.req_ready = '0;
        if (state_q == ArbBurst) begin
            bus_io.req_ready = grant_q & {NumReq{bus_io.tx_ready}};
        end
        xfer    = bus_io.tx_valid && bus_io.tx_ready;
        cnt_inc = cnt_q + CntW'(1);
    end

`ifdef USB_TX_ARB_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(USB_TX_STALL_TIMEOUT + 1);
    logic [StallW-1:0] stall_q;
    logic              timeout_q;
    logic [StallW-1:0] stall_inc;

    assign stall_inc = stall_q + StallW'(1);
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // The pointer records the last winner so that requester becomes lowest priority next time.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ArbIdle;
            grant_q    <= '0;
            gidx_q     <= '0;
            ptr_q      <= IdxW'(NumReq - 1);
            cnt_q      <= '0;
            overflow_q <= 1'b0;
`ifdef USB_TX_ARB_TIMEOUT_EN
            stall_q    <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            overflow_q <= 1'b0;
`ifdef USB_TX_ARB_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            unique case (state_q)
                ArbIdle: begin
                    if (pick_any) begin
                        state_q <= ArbBurst;
                        grant_q <= pick_gnt;
                        gidx_q  <= pick_idx;
                        ptr_q   <= pick_idx;
                        cnt_q   <= '0;
`ifdef USB_TX_ARB_TIMEOUT_EN
                        stall_q <= '0;
`endif
                    end
                end
                ArbBurst: begin
                    if (xfer) begin
                        if (g_last) begin
                            state_q <= ArbIdle;
                            grant_q <= '0;
                        end else if (cnt_inc == CntW'(MaxBeats)) begin
                            state_q    <= ArbIdle;
                            grant_q    <= '0;
                            overflow_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
`ifdef USB_TX_ARB_TIMEOUT_EN
                    if (g_valid) begin
                        stall_q <= '0;
                    end else if (stall_inc == StallW'(USB_TX_STALL_TIMEOUT)) begin
                        state_q   <= ArbIdle;
                        grant_q   <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        stall_q <= stall_inc;
                    end
`endif
                end
                default: begin
                    state_q <= ArbIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant_o    = grant_q;
    assign busy_o     = (state_q == ArbBurst);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Self-checking bench for usb_tx_arbiter: directed vector table, corner sequences and
// randomized traffic against a packet-level round-robin reference model.
module tb_usb_tx_arbiter;

    localparam int NR = 2;
    localparam int MB = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usb_tx_arbiter_if #(.NumReq(NR)) bus ();
    logic [NR-1:0] grant;
    logic          busy;
    logic          ovf;
    logic          tmo;

    usb_tx_arbiter #(
        .NumReq     (NR),
        .MaxBeats   (MB)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus_io     (bus),
        .grant_o    (grant),
        .busy_o     (busy),
        .overflow_o (ovf),
        .timeout_o  (tmo)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  l;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        rdy;
        logic [1:0]  e_gnt;
        logic        e_val;
        logic [31:0] e_data;
        logic        e_busy;
        logic [1:0]  e_rdy;
    } vec_t;

    function automatic vec_t mk(logic [1:0] v, logic [1:0] l, logic [31:0] d0, logic [31:0] d1,
                                logic rdy, logic [1:0] g, logic ev, logic [31:0] ed,
                                logic eb, logic [1:0] er);
        vec_t t;
        t.v = v; t.l = l; t.d0 = d0; t.d1 = d1; t.rdy = rdy;
        t.e_gnt = g; t.e_val = ev; t.e_data = ed; t.e_busy = eb; t.e_rdy = er;
        return t;
    endfunction

    // Reference model: packet lists per requester, expected beat stream in grant order.
    int          model_ptr = NR - 1;
    logic [31:0] sdata [NR][$];
    bit          slast [NR][$];
    int          plen  [NR][$];
    int          sidx  [NR];
    logic [31:0] edata [$];
    int          esrc  [$];
    bit          elast [$];

    task automatic fill(input int npk, input int fixed_len);
        for (int r = 0; r < NR; r++) begin
            sdata[r].delete(); slast[r].delete(); plen[r].delete();
            for (int p = 0; p < npk; p++) begin
                automatic int len = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 8));
                plen[r].push_back(len);
                for (int b = 0; b < len; b++) begin
                    sdata[r].push_back($urandom);
                    slast[r].push_back(b == len - 1);
                end
            end
        end
    endtask

    task automatic build_expected();
        int pk [NR];
        int off [NR];
        edata.delete(); esrc.delete(); elast.delete();
        for (int r = 0; r < NR; r++) begin
            pk[r] = 0; off[r] = 0;
        end
        for (int n = 0; n < 1000; n++) begin
            automatic int w = -1;
            automatic int len;
            for (int o = 1; o <= NR; o++) begin
                automatic int c = (model_ptr + o) % NR;
                if (w < 0 && pk[c] < plen[c].size()) w = c;
            end
            if (w < 0) break;
            len = plen[w][pk[w]];
            for (int b = 0; b < len; b++) begin
                edata.push_back(sdata[w][off[w] + b]);
                esrc.push_back(w);
                elast.push_back(b == len - 1);
            end
            off[w] += len;
            pk[w]++;
            model_ptr = w;
        end
    endtask

    task automatic run_traffic(input int rdy_pct, input int gap_pct);
        int e;
        int cyc;
        bit bub;
        logic [NR-1:0] exp_g;
        e = 0; cyc = 0; bub = 1'b0;
        for (int r = 0; r < NR; r++) sidx[r] = 0;
        build_expected();
        while (e < edata.size() || bub) begin
            if (cyc > 5000) begin
                check("traffic_budget", e, edata.size());
                break;
            end
            cyc++;
            for (int r = 0; r < NR; r++) begin
                automatic bit has = sidx[r] < sdata[r].size();
                automatic bit gap = grant[r] && ($urandom_range(99) < gap_pct);
                bus.req_valid[r] = has && !gap;
                bus.req_data[r]  = has ? sdata[r][sidx[r]] : 32'h0;
                bus.req_last[r]  = has ? slast[r][sidx[r]] : 1'b0;
            end
            bus.tx_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (bub) begin
                check("bubble_busy", busy, 0);
                check("bubble_valid", bus.tx_valid, 0);
                bub = 1'b0;
            end
            check("ready_mask", bus.req_ready & ~grant, 0);
            if (bus.tx_valid && bus.tx_ready) begin
                if (e >= edata.size()) begin
                    check("extra_beat", bus.tx_valid, 0);
                end else begin
                    exp_g = '0;
                    exp_g[esrc[e]] = 1'b1;
                    check("beat_data", bus.tx_data, edata[e]);
                    check("beat_grant", grant, exp_g);
                    if (elast[e]) bub = 1'b1;
                    e++;
                end
            end
            for (int r = 0; r < NR; r++) begin
                if (bus.req_valid[r] && bus.req_ready[r]) sidx[r]++;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
    endtask

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent0, ovf_n, last_x, ovf_cyc, g1_cyc, stall, tmo_n, tmo_stall;
        bit stop0, v1done;

        tbl[0]  = mk(2'b01, 2'b00, 32'hA0, 32'h0,  1, 2'b00, 0, 32'h0,  0, 2'b00);
        tbl[1]  = mk(2'b01, 2'b00, 32'hA0, 32'h0,  1, 2'b01, 1, 32'hA0, 1, 2'b01);
        tbl[2]  = mk(2'b01, 2'b00, 32'hA1, 32'h0,  1, 2'b01, 1, 32'hA1, 1, 2'b01);
        tbl[3]  = mk(2'b01, 2'b00, 32'hA2, 32'h0,  1, 2'b01, 1, 32'hA2, 1, 2'b01);
        tbl[4]  = mk(2'b01, 2'b01, 32'hA3, 32'h0,  1, 2'b01, 1, 32'hA3, 1, 2'b01);
        tbl[5]  = mk(2'b00, 2'b00, 32'h0,  32'h0,  1, 2'b00, 0, 32'h0,  0, 2'b00);
        tbl[6]  = mk(2'b10, 2'b00, 32'h0,  32'hB0, 1, 2'b00, 0, 32'h0,  0, 2'b00);
        tbl[7]  = mk(2'b10, 2'b00, 32'h0,  32'hB0, 0, 2'b10, 1, 32'hB0, 1, 2'b00);
        tbl[8]  = mk(2'b10, 2'b00, 32'h0,  32'hB0, 1, 2'b10, 1, 32'hB0, 1, 2'b10);
        tbl[9]  = mk(2'b10, 2'b00, 32'h0,  32'hB1, 0, 2'b10, 1, 32'hB1, 1, 2'b00);
        tbl[10] = mk(2'b10, 2'b00, 32'h0,  32'hB1, 1, 2'b10, 1, 32'hB1, 1, 2'b10);
        tbl[11] = mk(2'b10, 2'b10, 32'h0,  32'hB2, 0, 2'b10, 1, 32'hB2, 1, 2'b00);
        tbl[12] = mk(2'b10, 2'b10, 32'h0,  32'hB2, 1, 2'b10, 1, 32'hB2, 1, 2'b10);
        tbl[13] = mk(2'b00, 2'b00, 32'h0,  32'h0,  0, 2'b00, 0, 32'h0,  0, 2'b00);

        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.tx_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", bus.tx_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_tmo", tmo, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single req0 packet, then req1 packet under toggling tx_ready.
        for (int i = 0; i < 14; i++) begin
            bus.req_valid   = tbl[i].v;
            bus.req_last    = tbl[i].l;
            bus.req_data[0] = tbl[i].d0;
            bus.req_data[1] = tbl[i].d1;
            bus.tx_ready    = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("tbl%0d_grant", i), grant, tbl[i].e_gnt);
            check($sformatf("tbl%0d_valid", i), bus.tx_valid, tbl[i].e_val);
            if (tbl[i].e_val) check($sformatf("tbl%0d_data", i), bus.tx_data, tbl[i].e_data);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_ready", i), bus.req_ready, tbl[i].e_rdy);
            @(posedge clk); #1;
        end
        model_ptr = 1;

        // Both requesters, four 3-beat packets each, full throughput.
        fill(4, 3);
        run_traffic(100, 0);

        // Randomized lengths, backpressure and mid-packet valid gaps.
        for (int k = 0; k < 3; k++) begin
            fill(6, 0);
            run_traffic(70, 15);
        end

        // Beat cap: req0 never sends last, req1 waits.
        sent0 = 0; ovf_n = 0; last_x = -1; ovf_cyc = -1; g1_cyc = -1;
        stop0 = 1'b0; v1done = 1'b0;
        bus.tx_ready = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            bus.req_valid[0] = !stop0 && (sent0 < MB + 5);
            bus.req_data[0]  = sent0;
            bus.req_last[0]  = 1'b0;
            bus.req_valid[1] = (cyc >= 3) && !v1done;
            bus.req_data[1]  = 32'hB1B1_0001;
            bus.req_last[1]  = 1'b1;
            @(negedge clk);
            if (ovf) begin
                ovf_n++;
                ovf_cyc = cyc;
                stop0 = 1'b1;
            end
            if (grant == 2'b01 && bus.tx_valid && bus.tx_ready) begin
                check("ovf_data", bus.tx_data, sent0);
                sent0++;
                last_x = cyc;
            end
            if (grant == 2'b10 && bus.tx_valid && bus.tx_ready && !v1done) begin
                g1_cyc = cyc;
                v1done = 1'b1;
            end
            @(posedge clk); #1;
            if (v1done && cyc > g1_cyc + 3) break;
        end
        check("ovf_beats", sent0, MB);
        check("ovf_pulses", ovf_n, 1);
        check("ovf_timing", ovf_cyc, last_x + 1);
        check("ovf_next_grant", g1_cyc, ovf_cyc + 1);
        bus.req_valid = '0;
        bus.req_last  = '0;
        @(posedge clk); #1;

        // Stall: req0 sends 2 beats without last, then drops valid.
        sent0 = 0; stall = 0; tmo_n = 0; tmo_stall = -1;
        for (int cyc = 0; cyc < 1110; cyc++) begin
            bus.req_valid[0] = (sent0 < 2);
            bus.req_data[0]  = sent0;
            bus.req_last[0]  = 1'b0;
            bus.req_valid[1] = 1'b0;
            @(negedge clk);
            if (bus.tx_valid && bus.tx_ready) sent0++;
            if (grant == 2'b01 && !bus.req_valid[0]) stall++;
            if (tmo) begin
                tmo_n++;
                tmo_stall = stall;
            end
            @(posedge clk); #1;
        end
`ifdef USB_TX_ARB_TIMEOUT_EN
        check("tmo_stall_cycles", tmo_stall, 1024);
        check("tmo_pulses", tmo_n, 1);
        check("tmo_grant_after", grant, 0);
        check("tmo_busy_after", busy, 0);
`else
        check("stall_held_cycles", stall, 1107);
        check("stall_grant_held", grant, 2'b01);
        check("tmo_pulses", tmo_n, 0);
`endif

        // Reset mid-packet, then req0 must win the first arbitration.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        sent0 = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            bus.req_valid    = 2'b01;
            bus.req_data[0]  = 32'hC000_0000 + sent0;
            bus.req_last     = '0;
            bus.tx_ready     = 1'b1;
            @(negedge clk);
            if (cyc < 2) begin
                if (bus.tx_valid && bus.tx_ready) sent0++;
                @(posedge clk); #1;
            end
        end
        check("pre_rst_grant", grant, 2'b01);
        check("pre_rst_data", bus.tx_data, 32'hC000_0001);
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", grant, 0);
        check("mid_rst_valid", bus.tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        bus.req_valid = 2'b11;
        bus.req_last  = 2'b11;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_grant", grant, 2'b01);
        bus.req_valid = '0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
